// File: rtl/seg7_scan_n.sv
// Multiplexed common-anode 7-segment scanner: DIGITS hex digits, PWM brightness,
// frame-synchronous input shadowing. Optional leading-zero blanking via SEG7_LZB_EN.
module seg7_scan_n #(
    parameter int DIGITS    = 4,
    parameter int PHASE_LEN = 50000,
    parameter int BRIGHT_W  = 3
) (
    input  logic                  CLK,
    input  logic                  IN_CLR,
    input  logic [4*DIGITS-1:0]   D,
    input  logic [DIGITS-1:0]     DP,
    input  logic                  BLANK_LZ,
    input  logic [BRIGHT_W-1:0]   BRIGHT,
    output logic [7:0]            PATTERN,
    output logic [DIGITS-1:0]     DIGIT,
    output logic                  FRAME
);

    localparam int PH_W  = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PH_W-1:0]  PH_MAX  = PH_W'(PHASE_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

    logic [PH_W-1:0]         phase_cnt;
    logic [BRIGHT_W-1:0]     step;
    logic [IDX_W-1:0]        idx;
    logic                    run;
    logic [DIGITS-1:0][3:0]  shadow_d;
    logic [DIGITS-1:0]       shadow_dp;

    logic                    phase_wrap, step_wrap, frame_wrap;
    logic                    lit, blank;
    logic [6:0]              seg;
    logic [7:0]              pattern_nxt;
    logic [DIGITS-1:0]       digit_nxt;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    assign phase_wrap = (phase_cnt == PH_MAX);
    assign step_wrap  = phase_wrap && (step == '1);
    assign frame_wrap = step_wrap && (idx == IDX_MAX);

`ifdef SEG7_LZB_EN
    // zero_from[i]: digit i and every higher digit hold zero in the shadow
    logic [DIGITS-1:0] zero_from;
    assign zero_from[DIGITS-1] = (shadow_d[DIGITS-1] == 4'h0);
    for (genvar i = 0; i < DIGITS - 1; i++) begin : g_lz
        assign zero_from[i] = zero_from[i+1] && (shadow_d[i] == 4'h0);
    end
    assign blank = BLANK_LZ && (idx != '0) && zero_from[idx];
`else
    logic unused_blank_lz;
    assign unused_blank_lz = BLANK_LZ;
    assign blank = 1'b0;
`endif

    always_comb begin
        lit         = (step <= BRIGHT);
        seg         = blank ? 7'h7F : hex7(shadow_d[idx]);
        pattern_nxt = 8'hFF;
        digit_nxt   = '1;
        if (lit) begin
            pattern_nxt = {~shadow_dp[idx], seg};
            digit_nxt   = ~(DIGITS'(1) << idx);
        end
    end

    // run holds the counters for one cycle after reset so slot 0 is full length
    always_ff @(posedge CLK) begin
        if (IN_CLR) begin
            phase_cnt <= '0;
            step      <= '0;
            idx       <= '0;
            run       <= 1'b0;
            shadow_d  <= D;
            shadow_dp <= DP;
            PATTERN   <= 8'hFF;
            DIGIT     <= '1;
            FRAME     <= 1'b0;
        end else begin
            run     <= 1'b1;
            PATTERN <= 8'hFF;
            DIGIT   <= '1;
            FRAME   <= 1'b0;
            if (run) begin
                PATTERN   <= pattern_nxt;
                DIGIT     <= digit_nxt;
                FRAME     <= frame_wrap;
                phase_cnt <= phase_wrap ? '0 : phase_cnt + 1'b1;
                if (phase_wrap)
                    step <= step + 1'b1;
                if (step_wrap)
                    idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
                if (frame_wrap) begin
                    shadow_d  <= D;
                    shadow_dp <= DP;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_n.sv
// Directed bench for seg7_scan_n (4 digits, 8-clock slot, 32-clock frame) with an
// expected-output queue filled as stimulus is applied and drained cycle by cycle.
module tb_seg7_scan_n;

    logic        CLK = 1'b0;
    logic        IN_CLR;
    logic [15:0] D;
    logic [3:0]  DP;
    logic        BLANK_LZ;
    logic [1:0]  BRIGHT;
    logic [7:0]  PATTERN;
    logic [3:0]  DIGIT;
    logic        FRAME;

    typedef struct {
        logic [7:0] pat;
        logic [3:0] dig;
        logic       frm;
    } exp_t;

    exp_t  sb[$];
    string cur_tag;
    int    checks = 0;
    int    fails  = 0;

    seg7_scan_n #(.DIGITS(4), .PHASE_LEN(2), .BRIGHT_W(2)) dut (
        .CLK(CLK), .IN_CLR(IN_CLR), .D(D), .DP(DP), .BLANK_LZ(BLANK_LZ),
        .BRIGHT(BRIGHT), .PATTERN(PATTERN), .DIGIT(DIGIT), .FRAME(FRAME)
    );

    always #5 CLK = ~CLK;

    task automatic push_blank(input int n);
        exp_t e;
        e.pat = 8'hFF; e.dig = 4'hF; e.frm = 1'b0;
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    // Expected outputs of one frame: slot k = clocks 8k..8k+7, step = (clock%8)/2,
    // digit lit while step <= bright, FRAME on the frame's last clock.
    task automatic push_frame(input logic [7:0] p0, input logic [7:0] p1,
                              input logic [7:0] p2, input logic [7:0] p3,
                              input int bright, input int ncyc);
        logic [7:0] p[4];
        exp_t e;
        int k, s;
        p = '{p0, p1, p2, p3};
        for (int n = 0; n < ncyc; n++) begin
            k = n / 8;
            s = (n % 8) / 2;
            if (s <= bright) begin
                e.pat = p[k];
                e.dig = ~(4'b0001 << k);
            end else begin
                e.pat = 8'hFF;
                e.dig = 4'hF;
            end
            e.frm = (n == 31);
            sb.push_back(e);
        end
    endtask

    task automatic run(input int n);
        exp_t e;
        logic [12:0] obs, want;
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $error("FAIL %s: observed output with no expectation queued (required one)", cur_tag);
            end else begin
                e    = sb.pop_front();
                obs  = {PATTERN, DIGIT, FRAME};
                want = {e.pat, e.dig, e.frm};
                assert (obs === want) else begin
                    fails++;
                    $error("FAIL %s: observed pat=%h dig=%h frm=%b, expected pat=%h dig=%h frm=%b",
                           cur_tag, PATTERN, DIGIT, FRAME, e.pat, e.dig, e.frm);
                end
            end
        end
    endtask

    logic [7:0] lz_pat;

    initial begin
`ifdef SEG7_LZB_EN
        lz_pat = 8'hFF;
`else
        lz_pat = 8'hC0;
`endif
        IN_CLR = 1'b1; D = 16'h5AF1; DP = 4'b0100; BLANK_LZ = 1'b0; BRIGHT = 2'd3;

        cur_tag = "reset";     push_blank(3); run(3);
        IN_CLR = 1'b0;
        cur_tag = "release";   push_blank(1); run(1);

        cur_tag = "scan_full"; push_frame(8'hF9, 8'h8E, 8'h08, 8'h92, 3, 32); run(32);
        cur_tag = "scan_full2"; push_frame(8'hF9, 8'h8E, 8'h08, 8'h92, 3, 32); run(32);

        BRIGHT = 2'd1;
        cur_tag = "bright1";   push_frame(8'hF9, 8'h8E, 8'h08, 8'h92, 1, 32); run(32);
        BRIGHT = 2'd0;
        cur_tag = "bright0";   push_frame(8'hF9, 8'h8E, 8'h08, 8'h92, 0, 32); run(32);

        BRIGHT = 2'd3;
        cur_tag = "tear_old";  push_frame(8'hF9, 8'h8E, 8'h08, 8'h92, 3, 32);
        run(10); D = 16'h6908; run(22);
        cur_tag = "tear_new";  push_frame(8'h80, 8'hC0, 8'h10, 8'h82, 3, 32);
        run(10); D = 16'h0070; DP = 4'b0000; BLANK_LZ = 1'b1; run(22);

        cur_tag = "lz_on";     push_frame(8'hC0, 8'hF8, lz_pat, lz_pat, 3, 32); run(32);
        BLANK_LZ = 1'b0;
        cur_tag = "lz_off";    push_frame(8'hC0, 8'hF8, 8'hC0, 8'hC0, 3, 32); run(32);

        cur_tag = "pre_rst";   push_frame(8'hC0, 8'hF8, 8'hC0, 8'hC0, 3, 17); run(17);
        IN_CLR = 1'b1;
        cur_tag = "mid_rst";   push_blank(1); run(1);
        IN_CLR = 1'b0;
        cur_tag = "mid_rel";   push_blank(1); run(1);
        cur_tag = "restart";   push_frame(8'hC0, 8'hF8, 8'hC0, 8'hC0, 3, 32); run(32);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
